// File: rtl/stack_to_bcd.sv
// Sequential double-dabble converter: stack-top binary to packed BCD for the digit bus.
// Optional BCD_SIGNED_EN: treat bin_data as two's complement and report the sign on neg.
module stack_to_bcd #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  input  logic [BIN_W-1:0]      bin_data,
  output logic [4*DIGITS-1:0]   numbers,
  output logic                  overflow,
  output logic                  neg,
  output logic                  busy,
  output logic                  done
);

  localparam int SW      = 4 * (DIGITS + 1);
  localparam int CW      = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int LIMIT_I = 10**DIGITS - 1;
  localparam logic [BIN_W:0] LIMIT = (BIN_W+1)'(LIMIT_I);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [BIN_W-1:0]      r_shift;
  logic [SW-1:0]         r_scratch;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf_next;
  logic                  r_carry;
  logic [4*DIGITS-1:0]   r_numbers;
  logic                  r_overflow;
  logic                  r_done;
  logic [BIN_W:0]        w_mag;
  logic [SW-1:0]         w_adj;
  logic [4*DIGITS-1:0]   w_rev;
  logic                  w_accept;
  logic                  w_force_nines;

`ifdef BCD_SIGNED_EN
  logic w_sign;
  logic r_neg_next;
  logic r_neg;

  // Magnitude is formed one bit wider so the most negative input negates cleanly.
  assign w_sign = bin_data[BIN_W-1];
  assign w_mag  = w_sign ? ((BIN_W+1)'(0) - {w_sign, bin_data}) : {1'b0, bin_data};
  assign neg    = r_neg;
`else
  assign w_mag  = {1'b0, bin_data};
  assign neg    = 1'b0;
`endif

  assign w_accept = bin_valid & bin_ready;
  assign numbers  = r_numbers;
  assign overflow = r_overflow;
  assign done     = r_done;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) : r_scratch[4*gi +: 4];
    end
    // Display wants the most significant digit in the lowest nibble.
    for (gi = 0; gi < DIGITS; gi++) begin : g_rev
      assign w_rev[4*gi +: 4] = r_scratch[4*(DIGITS-1-gi) +: 4];
    end
  endgenerate

  // Any digit beyond the display width, or a lost carry, must never reach the bus.
  assign w_force_nines = r_ovf_next | r_carry | (|r_scratch[SW-1 -: 4]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    bin_ready    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        bin_ready = 1'b1;
        if (bin_valid) w_state_next = S_CONV;
      end
      S_CONV: begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      r_carry    <= 1'b0;
      r_numbers  <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
`ifdef BCD_SIGNED_EN
      r_neg_next <= 1'b0;
      r_neg      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift    <= w_mag[BIN_W-1:0];
            r_scratch  <= '0;
            r_cnt      <= CW'(BIN_W - 1);
            r_ovf_next <= (w_mag > LIMIT);
            r_carry    <= 1'b0;
`ifdef BCD_SIGNED_EN
            r_neg_next <= w_sign;
`endif
          end
        end
        S_CONV: begin
          r_scratch <= {w_adj[SW-2:0], r_shift[BIN_W-1]};
          r_shift   <= {r_shift[BIN_W-2:0], 1'b0};
          r_carry   <= r_carry | w_adj[SW-1];
          r_cnt     <= r_cnt - CW'(1);
        end
        S_DONE: begin
          r_numbers  <= w_force_nines ? {DIGITS{4'h9}} : w_rev;
          r_overflow <= r_ovf_next;
          r_done     <= 1'b1;
`ifdef BCD_SIGNED_EN
          r_neg      <= r_neg_next;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_to_bcd.sv
// Directed bench for stack_to_bcd: latency, digit order, overflow clamp, back-to-back, reset abort.
module tb_stack_to_bcd;

  logic        clk;
  logic        rst_n;
  logic        bin_valid;
  logic        bin_ready;
  logic [15:0] bin_data;
  logic [15:0] numbers;
  logic        overflow;
  logic        neg;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] prev_num;

  stack_to_bcd #(.BIN_W(16), .DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .bin_data  (bin_data),
    .numbers   (numbers),
    .overflow  (overflow),
    .neg       (neg),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Caller is 1 time unit after a posedge with the DUT idle.
  task automatic convert(input logic [15:0] v, input logic [15:0] exp_num,
                         input logic exp_ovf, input logic exp_neg, input string tag);
    int k;
    bin_data  = v;
    bin_valid = 1'b1;
    @(posedge clk); #1;
    bin_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_rdy_lo"}, bin_ready, 0);
    @(posedge clk); #1;
    check({tag, "_hold"}, numbers, prev_num);
    k = 1;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_lat"}, k, 17);
    check({tag, "_num"}, numbers, exp_num);
    check({tag, "_ovf"}, overflow, exp_ovf);
    check({tag, "_neg"}, neg, exp_neg);
    check({tag, "_rdy_hi"}, bin_ready, 1);
    prev_num = exp_num;
  endtask

  initial begin
    int k;
    int n_done;
    rst_n     = 1'b0;
    bin_valid = 1'b0;
    bin_data  = 16'h0;
    prev_num  = 16'h0;
    #1;
    check("rst_num", numbers, 0);
    check("rst_rdy", bin_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_neg", neg, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    convert(16'd1234,  16'h4321, 1'b0, 1'b0, "v1234");
    convert(16'd0,     16'h0000, 1'b0, 1'b0, "v0");
    convert(16'd9999,  16'h9999, 1'b0, 1'b0, "v9999");
    convert(16'd10000, 16'h9999, 1'b1, 1'b0, "v10000");
    convert(16'd7,     16'h7000, 1'b0, 1'b0, "v7");
    convert(16'd59,    16'h9500, 1'b0, 1'b0, "v59");
    convert(16'd1000,  16'h0001, 1'b0, 1'b0, "v1000");
    convert(16'd8765,  16'h5678, 1'b0, 1'b0, "v8765");

    // valid held high across DONE: B must be taken at the first idle edge
    bin_data  = 16'd5;
    bin_valid = 1'b1;
    @(posedge clk); #1;
    bin_data = 16'd6;
    check("hold_rdy_t1", bin_ready, 0);
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("hold_a_lat", k, 17);
    check("hold_a_num", numbers, 16'h5000);
    @(posedge clk); #1;
    bin_valid = 1'b0;
    check("hold_b_acc", busy, 1);
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("hold_b_lat", k, 17);
    check("hold_b_num", numbers, 16'h6000);
    n_done = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("hold_no_dup", n_done, 0);
    prev_num = 16'h6000;

    convert(16'd10000, 16'h9999, 1'b1, 1'b0, "pre_rst");

    // asynchronous reset in the middle of a conversion
    bin_data  = 16'd4321;
    bin_valid = 1'b1;
    @(posedge clk); #1;
    bin_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_num", numbers, 0);
    check("abort_busy", busy, 0);
    check("abort_rdy", bin_ready, 1);
    check("abort_ovf", overflow, 0);
    check("abort_done", done, 0);
    #2 rst_n = 1'b1;
    n_done = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    prev_num = 16'h0;

    convert(16'd1234, 16'h4321, 1'b0, 1'b0, "recover");
`ifdef BCD_SIGNED_EN
    convert(16'hFFD6, 16'h2400, 1'b0, 1'b1, "sneg42");
    convert(16'h8000, 16'h9999, 1'b1, 1'b1, "smin");
    convert(16'hD8F0, 16'h9999, 1'b1, 1'b1, "sneg10000");
    convert(16'd42,   16'h2400, 1'b0, 1'b0, "spos42");
`else
    convert(16'hFFFF, 16'h9999, 1'b1, 1'b0, "umax");
    convert(16'hFFD6, 16'h9999, 1'b1, 1'b0, "u65494");
    convert(16'd42,   16'h2400, 1'b0, 1'b0, "u42");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
